// File: rtl/rotor_stepper_if.sv
// Handshake bundle between the keypress/load source and the rotor stepping controller.
// Positions come out zero-extended to POS_W for the substitution stage.
interface rotor_stepper_if #(
  parameter int POS_W = 8
);
  logic             key_in;
  logic             load_init;
  logic [4:0]       init_l;
  logic [4:0]       init_m;
  logic [4:0]       init_r;
  logic [POS_W-1:0] pos_l;
  logic [POS_W-1:0] pos_m;
  logic [POS_W-1:0] pos_r;
  logic             pos_valid;
  logic             busy;
  logic [15:0]      step_count;

  modport master (
    output key_in, load_init, init_l, init_m, init_r,
    input  pos_l, pos_m, pos_r, pos_valid, busy, step_count
  );

  modport slave (
    input  key_in, load_init, init_l, init_m, init_r,
    output pos_l, pos_m, pos_r, pos_valid, busy, step_count
  );
endinterface

// File: rtl/rotor_stepper.sv
// Enigma-style three-rotor stepping controller: one odometer step per key edge,
// with middle-rotor double-step, sanitised position loading and a publish strobe.
module rotor_stepper #(
  parameter int NOTCH_R = 21,
  parameter int NOTCH_M = 4,
  parameter int POS_W   = 8
) (
  input  logic            clk,
  input  logic            resetn,
  rotor_stepper_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STEP    = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        key_q;
  logic        key_rise;
  logic [4:0]  pos_l_q;
  logic [4:0]  pos_m_q;
  logic [4:0]  pos_r_q;
  logic [4:0]  step_l;
  logic [4:0]  step_m;
  logic [4:0]  step_r;
  logic        carry_r;
  logic        carry_m;
  logic [15:0] count_q;

  // Wrap is decided by comparison, never by letting the 5-bit add overflow.
  function automatic logic [4:0] inc_wrap(input logic [4:0] v);
    inc_wrap = (v == 5'd25) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [4:0] sanitize(input logic [4:0] v);
    sanitize = (v > 5'd25) ? 5'd0 : v;
  endfunction

  assign key_rise = bus.key_in & ~key_q;

  // Stepping rule on pre-step positions: middle at its notch drags itself and left.
  always_comb begin
    carry_r = (pos_r_q == 5'(NOTCH_R));
    carry_m = (pos_m_q == 5'(NOTCH_M));
    step_r  = inc_wrap(pos_r_q);
    step_m  = (carry_r || carry_m) ? inc_wrap(pos_m_q) : pos_m_q;
    step_l  = carry_m ? inc_wrap(pos_l_q) : pos_l_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      key_q <= 1'b0;
    end else begin
      state <= state_nxt;
      key_q <= bus.key_in;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (key_rise) state_nxt = STEP;
      STEP:    state_nxt = PUBLISH;
      PUBLISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Load wins over any step in flight and over a simultaneous edge.
    if (bus.load_init) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pos_l_q <= 5'd0;
      pos_m_q <= 5'd0;
      pos_r_q <= 5'd0;
      count_q <= 16'd0;
    end else if (bus.load_init) begin
      pos_l_q <= sanitize(bus.init_l);
      pos_m_q <= sanitize(bus.init_m);
      pos_r_q <= sanitize(bus.init_r);
      count_q <= 16'd0;
    end else begin
      if (state == STEP) begin
        pos_l_q <= step_l;
        pos_m_q <= step_m;
        pos_r_q <= step_r;
      end
      if (state == PUBLISH) count_q <= count_q + 16'd1;
    end
  end

  assign bus.pos_l      = POS_W'(pos_l_q);
  assign bus.pos_m      = POS_W'(pos_m_q);
  assign bus.pos_r      = POS_W'(pos_r_q);
  assign bus.pos_valid  = (state == PUBLISH) && !bus.load_init;
  assign bus.busy       = (state != IDLE);
  assign bus.step_count = count_q;

endmodule

// File: tb/tb_rotor_stepper.sv
// Directed and randomized bench for rotor_stepper against an arithmetic Enigma
// odometer model (positions as plain integers modulo 26).
module tb_rotor_stepper;

  localparam int NR = 21;
  localparam int NM = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   ml, mm, mr, mcnt;

  rotor_stepper_if #(.POS_W(8)) bus ();

  rotor_stepper #(.NOTCH_R(NR), .NOTCH_M(NM), .POS_W(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pos(input string tag);
    chk({tag, "_l"}, int'(bus.pos_l), ml);
    chk({tag, "_m"}, int'(bus.pos_m), mm);
    chk({tag, "_r"}, int'(bus.pos_r), mr);
  endtask

  task automatic model_step();
    int ol, om, orr;
    ol = ml; om = mm; orr = mr;
    mr = (orr + 1) % 26;
    if (orr == NR || om == NM) mm = (om + 1) % 26;
    if (om == NM) ml = (ol + 1) % 26;
    mcnt = (mcnt + 1) % 65536;
  endtask

  // Press the key, hold it 'hold' cycles beyond the step, then release.
  task automatic press(input int hold);
    model_step();
    @(negedge clk);
    bus.key_in = 1'b1;
    for (int c = 1; c <= hold + 2; c++) begin
      @(negedge clk);
      chk("pos_valid", int'(bus.pos_valid), (c == 2) ? 1 : 0);
      if (c == 1) chk("busy_step", int'(bus.busy), 1);
      if (c == 2) begin
        chk("busy_pub", int'(bus.busy), 1);
        chk_pos("step_pos");
      end
      if (c == 3) begin
        chk("busy_idle", int'(bus.busy), 0);
        chk("step_count", int'(bus.step_count), mcnt);
      end
    end
    bus.key_in = 1'b0;
  endtask

  task automatic do_load(input int l, input int m, input int r, input int cycles);
    @(negedge clk);
    bus.load_init = 1'b1;
    bus.init_l = 5'(l);
    bus.init_m = 5'(m);
    bus.init_r = 5'(r);
    repeat (cycles) @(negedge clk);
    bus.load_init = 1'b0;
    ml = (l > 25) ? 0 : l;
    mm = (m > 25) ? 0 : m;
    mr = (r > 25) ? 0 : r;
    mcnt = 0;
    chk_pos("load_pos");
    chk("load_count", int'(bus.step_count), 0);
    chk("load_valid", int'(bus.pos_valid), 0);
  endtask

  initial begin
    int pulses;
    bus.key_in = 1'b0;
    bus.load_init = 1'b0;
    bus.init_l = 5'd0;
    bus.init_m = 5'd0;
    bus.init_r = 5'd0;
    ml = 0; mm = 0; mr = 0; mcnt = 0;

    // Reset state
    #12;
    chk_pos("rst_pos");
    chk("rst_valid", int'(bus.pos_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_count", int'(bus.step_count), 0);
    @(negedge clk);
    resetn = 1'b1;

    // Single long press
    do_load(0, 0, 0, 1);
    press(10);
    chk("first_r", int'(bus.pos_r), 1);
    chk("first_cnt", int'(bus.step_count), 1);

    // ADU -> ADV -> AEW -> BFX
    do_load(0, 3, 20, 1);
    press(1); press(2); press(1);
    chk("bfx_l", int'(bus.pos_l), 1);
    chk("bfx_m", int'(bus.pos_m), 5);
    chk("bfx_r", int'(bus.pos_r), 23);

    // Wrap cases
    do_load(25, 25, 25, 1);
    press(1);
    chk("zzz_m", int'(bus.pos_m), 25);
    chk("zzz_r", int'(bus.pos_r), 0);
    do_load(0, 25, 21, 1);
    press(1);
    chk("carry_m", int'(bus.pos_m), 0);
    chk("carry_r", int'(bus.pos_r), 22);

    // Sanitised load then step with default right notch
    do_load(30, 26, 25, 1);
    press(1);
    chk("san_m", int'(bus.pos_m), 0);
    chk("san_r", int'(bus.pos_r), 0);

    // Load one cycle after the edge aborts the step
    @(negedge clk);
    bus.key_in = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(bus.busy), 1);
    bus.load_init = 1'b1;
    bus.init_l = 5'd7; bus.init_m = 5'd7; bus.init_r = 5'd7;
    @(negedge clk);
    bus.load_init = 1'b0;
    ml = 7; mm = 7; mr = 7; mcnt = 0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_valid", int'(bus.pos_valid), 0);
    end
    chk_pos("abort_pos");
    chk("abort_count", int'(bus.step_count), 0);
    bus.key_in = 1'b0;

    // Second edge while busy is dropped
    @(negedge clk);
    bus.key_in = 1'b1;
    model_step();
    pulses = 0;
    @(negedge clk);
    bus.key_in = 1'b0;
    @(negedge clk);
    if (bus.pos_valid) pulses++;
    bus.key_in = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.pos_valid) pulses++;
    end
    bus.key_in = 1'b0;
    chk("busy_edge_pulses", pulses, 1);
    chk_pos("busy_edge_pos");
    chk("busy_edge_count", int'(bus.step_count), mcnt);

    // Held load with key rising underneath: no step afterwards
    @(negedge clk);
    bus.load_init = 1'b1;
    bus.init_l = 5'd2; bus.init_m = 5'd4; bus.init_r = 5'd21;
    @(negedge clk);
    bus.key_in = 1'b1;
    repeat (2) @(negedge clk);
    bus.load_init = 1'b0;
    ml = 2; mm = 4; mr = 21; mcnt = 0;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.pos_valid) pulses++;
    end
    bus.key_in = 1'b0;
    chk("held_load_pulses", pulses, 0);
    chk_pos("held_load_pos");
    press(1);

    // Randomized loads and presses, biased toward notch positions
    for (int k = 0; k < 12; k++) begin
      int il, im, ir, sel;
      sel = int'($urandom_range(0, 3));
      il = int'($urandom_range(0, 31));
      im = (sel == 0) ? NM : ((sel == 1) ? NM - 1 : int'($urandom_range(0, 31)));
      ir = (sel == 2) ? NR : ((sel == 3) ? 25 : int'($urandom_range(0, 31)));
      do_load(il, im, ir, int'($urandom_range(1, 3)));
      repeat (int'($urandom_range(1, 6))) press(int'($urandom_range(1, 4)));
    end

    // Reset in PUBLISH, then 26 presses from zero
    @(negedge clk);
    bus.key_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_valid", int'(bus.pos_valid), 1);
    #2;
    resetn = 1'b0;
    #1;
    ml = 0; mm = 0; mr = 0; mcnt = 0;
    chk_pos("midrst_pos");
    chk("midrst_valid", int'(bus.pos_valid), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_count", int'(bus.step_count), 0);
    bus.key_in = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 26; k++) press(1);
    chk("p26_l", int'(bus.pos_l), 0);
    chk("p26_m", int'(bus.pos_m), 1);
    chk("p26_r", int'(bus.pos_r), 0);
    chk("p26_count", int'(bus.step_count), 26);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rotor_stepper.md
Name: rotor_stepper

Overview:
- Upstream stepping controller for the three-rotor stack (left, middle, right).
- Converts debounced keypress levels into one step event per key.
- Applies Enigma odometer stepping with the middle-rotor double-step.
- Holds the three rotor positions (0..25) and publishes them with a one-cycle valid strobe, consumed by the substitution stage.
- Handles initial-position loading with range sanitising: any value >25 becomes 0.

Parameters:
- NOTCH_R, 21: right-rotor turnover position; the middle rotor steps when right is here at keypress.
- NOTCH_M, 4: middle-rotor turnover position; double-step trigger.
- POS_W, 8: output position width; zero-extended.

Ports:
- clk  in  1  system clock, all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- key_in  in  1  debounced keypress level; high while the key is held.
- load_init  in  1  synchronous load request, level-sampled each cycle.
- init_l  in  5  left initial position.
- init_m  in  5  middle initial position.
- init_r  in  5  right initial position.
- pos_l  out  POS_W  current left position.
- pos_m  out  POS_W  current middle position.
- pos_r  out  POS_W  current right position.
- pos_valid  out  1  one-cycle strobe: positions have just been updated by a step.
- busy  out  1  high while a step is in flight (STEP or PUBLISH).
- step_count  out  16  number of completed steps since reset/load; wraps at 65535->0.

Behaviour:
- Reset (resetn=0, async): positions 0/0/0, pos_valid=0, busy=0, step_count=0, FSM=IDLE, key edge register=0.
- Edge detect: key_q registers key_in every cycle. key_rise = key_in & ~key_q. Exactly one step per rising edge, regardless of hold length.
- FSM states:
  - IDLE: busy=0. On key_rise with load_init=0 -> STEP.
  - STEP: busy=1. Compute and register the new positions in this cycle -> PUBLISH.
  - PUBLISH: busy=1, pos_valid=1 for exactly this cycle, step_count+1 -> IDLE.
- Latency: edge sampled at cycle N; positions change at the end of N+1; pos_valid high in N+2; ready for a new edge from N+3.
- key_rise while busy: ignored, not queued. key_q still tracks, so a key that stays held does not step later.
- Stepping rule, evaluated on pre-step positions:
  - r always +1.
  - m +1 if r==NOTCH_R or m==NOTCH_M.
  - l +1 if m==NOTCH_M (double-step).
  - Each position wraps 25->0.
- Arithmetic: 5-bit internal registers. Compare ==25 before increment, never rely on overflow. Outputs are zero-extended to POS_W.
- Load: load_init=1 in any state has priority over everything.
  - Positions <= init values, each >25 replaced by 0.
  - step_count=0, FSM -> IDLE, pos_valid=0 that cycle.
  - An in-flight step is aborted and no strobe is issued.
  - A key_rise in the same cycle is discarded.
- Load held for several cycles: reloads every cycle. Stepping resumes only on a key_rise after load_init falls.
- Reset mid-step: immediate async clear, no pos_valid.

Test Plan:
- Reset then load 0/0/0; press key once, holding it 10 cycles -> exactly one pos_valid two cycles after the edge; positions 0/0/1; step_count=1.
- Load l=0,m=3,r=20 (A,D,U); three separate presses -> 0/3/21, then 0/4/22, then 1/5/23 (ADV, AEW, BFX double-step).
- Load 25/25/25 (NOTCH defaults); one press -> 25/25/0. Load 0/25/21; one press -> 0/0/22 (wrap with carry).
- Load init_l=30, init_m=26, init_r=25 -> 0/0/25. Then one press -> 0/1/0 only when NOTCH_R=25; with the default NOTCH_R -> 0/0/0.
- Key edge at N, load_init pulse at N+1 with 7/7/7 -> no pos_valid; positions 7/7/7; step_count=0. Second key edge during busy -> ignored.
- Assert resetn low during PUBLISH -> all outputs 0 immediately. After release, 26 presses from 0/0/0 -> 0/1/0, step_count=26.
